// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR conversion controller.
package sar_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_TRIAL  = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_e;

    // Default parameter values
    localparam int SAR_WIDTH_DEF    = 12;
    localparam int SAR_SETTLE_DEF   = 1;
    localparam int SAR_SAMPLE_DEF   = 2;
    localparam int SAR_CHANNELS_DEF = 4;

    // Number of conversions averaged when averaging is built in
    localparam int SAR_AVG_COUNT = 4;

endpackage

// File: rtl/sar_settle_cnt.sv
// Phase timer for the SAR controller: a down-counter that is reloaded with the
// track length or the per-bit settle length and flags the last cycle of it.
module sar_settle_cnt #(
    parameter int SETTLE        = 1,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic sel_sample,
    output logic last
);

    localparam int MAXLEN = (SETTLE > SAMPLE_CYCLES) ? SETTLE : SAMPLE_CYCLES;
    localparam int CNTW   = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam logic [CNTW-1:0] LOAD_SAMPLE = CNTW'(SAMPLE_CYCLES - 1);
    localparam logic [CNTW-1:0] LOAD_SETTLE = CNTW'(SETTLE - 1);

    logic [CNTW-1:0] cnt_q, cnt_d;

    // Reload on a phase or bit change, otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = sel_sample ? LOAD_SAMPLE : LOAD_SETTLE;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: track phase, MSB-first bit trials,
// one-cycle DONE with a result_valid pulse, abort and channel tagging.
// Build option: define SAR_AVG4_EN to run four track+trial passes per start
// on the same channel and report the truncated average of the four codes.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for start with an in-range chan_sel
// ST_SAMPLE  | track phase, sample=1, DAC at zero
// ST_TRIAL   | bit trial for bit_q, cmp taken on the last settle cycle
// ST_DONE    | result loaded, result_valid high for this one cycle
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH         = SAR_WIDTH_DEF,
    parameter int SETTLE        = SAR_SETTLE_DEF,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_DEF,
    parameter int CHANNELS      = SAR_CHANNELS_DEF,
    // Derived channel-index width; leave at its default
    parameter int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CW-1:0]    chan_sel,
    input  logic             cmp,
    output logic             sample,
    output logic [CW-1:0]    chan,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    result_chan,
    output logic             result_valid
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] MSB_IDX = BW'(WIDTH - 1);

    sar_state_e       state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [CW-1:0]    chan_q, chan_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    result_chan_q, result_chan_d;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] trial_code;
    logic [WIDTH-1:0] final_code;
    logic             chan_ok;
    logic             phase_last;
    logic             cnt_restart;
    logic             cnt_sel_sample;

`ifdef SAR_AVG4_EN
    logic [WIDTH+1:0] acc_q, acc_d, acc_sum;
    logic [1:0]       pass_q, pass_d;
`endif

    assign bit_mask   = WIDTH'(1) << bit_q;
    assign trial_code = code_q | bit_mask;
    // Code after deciding the current bit: keep it only if Vin >= Vdac
    assign final_code = cmp ? trial_code : code_q;
    assign chan_ok    = (int'(chan_sel) < CHANNELS);

    sar_settle_cnt #(
        .SETTLE        (SETTLE),
        .SAMPLE_CYCLES (SAMPLE_CYCLES)
    ) u_settle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (cnt_restart),
        .sel_sample (cnt_sel_sample),
        .last       (phase_last)
    );

    // Next-state, bit stepping, result capture and timer reload requests
    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        code_d        = code_q;
        chan_d        = chan_q;
        result_d      = result_q;
        result_chan_d = result_chan_q;
        cnt_restart   = 1'b0;
`ifdef SAR_AVG4_EN
        acc_d         = acc_q;
        pass_d        = pass_q;
        acc_sum       = acc_q + (WIDTH+2)'(final_code);
`endif
        case (state_q)
            ST_IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort && chan_ok) begin
                    state_d     = ST_SAMPLE;
                    chan_d      = chan_sel;
                    code_d      = '0;
                    cnt_restart = 1'b1;
`ifdef SAR_AVG4_EN
                    acc_d       = '0;
                    pass_d      = '0;
`endif
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    code_d  = '0;
`ifdef SAR_AVG4_EN
                    acc_d   = '0;
                    pass_d  = '0;
`endif
                end else if (phase_last) begin
                    state_d     = ST_TRIAL;
                    bit_d       = MSB_IDX;
                    cnt_restart = 1'b1;
                end
            end
            ST_TRIAL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    code_d  = '0;
`ifdef SAR_AVG4_EN
                    acc_d   = '0;
                    pass_d  = '0;
`endif
                end else if (phase_last) begin
                    code_d      = final_code;
                    cnt_restart = 1'b1;
                    if (bit_q == '0) begin
`ifdef SAR_AVG4_EN
                        if (pass_q == 2'(SAR_AVG_COUNT - 1)) begin
                            state_d       = ST_DONE;
                            result_d      = WIDTH'(acc_sum >> 2);
                            result_chan_d = chan_q;
                            acc_d         = '0;
                            pass_d        = '0;
                        end else begin
                            state_d = ST_SAMPLE;
                            acc_d   = acc_sum;
                            pass_d  = pass_q + 2'd1;
                            code_d  = '0;
                        end
`else
                        state_d       = ST_DONE;
                        result_d      = final_code;
                        result_chan_d = chan_q;
`endif
                    end else begin
                        bit_d = bit_q - BW'(1);
                    end
                end
            end
            ST_DONE: begin
                // abort is deliberately not looked at here
                state_d = ST_IDLE;
                code_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cnt_sel_sample = (state_d == ST_SAMPLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_q         <= '0;
            code_q        <= '0;
            chan_q        <= '0;
            result_q      <= '0;
            result_chan_q <= '0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            code_q        <= code_d;
            chan_q        <= chan_d;
            result_q      <= result_d;
            result_chan_q <= result_chan_d;
        end
    end

`ifdef SAR_AVG4_EN
    // Averaging accumulator and pass counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            pass_q <= '0;
        end else begin
            acc_q  <= acc_d;
            pass_q <= pass_d;
        end
    end
`endif

    assign sample       = (state_q == ST_SAMPLE);
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_DONE);
    assign dac_code     = (state_q == ST_TRIAL) ? trial_code : '0;
    assign chan         = chan_q;
    assign result       = result_q;
    assign result_chan  = result_chan_q;

endmodule
